// File: rtl/score_ram_arbiter.sv
// Round-robin arbiter sharing one single-port score/level RAM between four requesters.
// Optional start-up RAM sweep enabled by defining RAM_CLEAR_EN.
module score_ram_arbiter #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic [3:0]      we,
  input  logic [4*AW-1:0] addr_in,
  input  logic [4*DW-1:0] wdata_in,
  output logic [3:0]      ack,
  output logic [3:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            busy,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  output logic            ram_we,
  input  logic [DW-1:0]   ram_rdata
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACCESS, S_RDWAIT} state_t;

`ifdef RAM_CLEAR_EN
  localparam state_t RESET_STATE = S_CLEAR;
  localparam int     CW          = $clog2(DEPTH + 1);
  logic [CW-1:0] r_clr_cnt;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  if (DEPTH > (1 << AW)) begin : g_bad_depth
    $error("DEPTH exceeds the RAM address space");
  end

  state_t     r_state, w_next;
  logic [1:0] r_ptr, r_win;
  logic [1:0] w_win, w_idx;
  logic       w_grant;

  // Winner: first requesting index at or above the pointer, wrapping mod 4.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_grant = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_ptr + 2'(i);
      if (req[w_idx]) begin
        w_grant = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
`ifdef RAM_CLEAR_EN
      S_CLEAR:  if (r_clr_cnt == CW'(DEPTH)) w_next = S_IDLE;
`else
      S_CLEAR:  w_next = S_IDLE;
`endif
      S_IDLE:   if (w_grant) w_next = S_ACCESS;
      S_ACCESS: w_next = ram_we ? S_IDLE : S_RDWAIT;
      S_RDWAIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= RESET_STATE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ack       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      r_ptr     <= '0;
      r_win     <= '0;
`ifdef RAM_CLEAR_EN
      r_clr_cnt <= '0;
`endif
    end else begin
      ack    <= '0;
      rvalid <= '0;
      busy   <= (w_next != S_IDLE);
      case (r_state)
        S_CLEAR: begin
`ifdef RAM_CLEAR_EN
          if (r_clr_cnt != CW'(DEPTH)) begin
            ram_we    <= 1'b1;
            ram_addr  <= AW'(r_clr_cnt);
            ram_wdata <= '0;
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end else begin
            ram_we <= 1'b0;
          end
`else
          ram_we <= 1'b0;
`endif
        end
        S_IDLE: begin
          ram_we <= 1'b0;
          if (w_grant) begin
            ram_addr     <= addr_in[w_win*AW +: AW];
            ram_wdata    <= wdata_in[w_win*DW +: DW];
            ram_we       <= we[w_win];
            ack[w_win]   <= 1'b1;
            r_win        <= w_win;
          end
        end
        S_ACCESS: begin
          ram_we <= 1'b0;
          r_ptr  <= r_win + 2'd1;
        end
        S_RDWAIT: begin
          rdata         <= ram_rdata;
          rvalid[r_win] <= 1'b1;
        end
        default: ram_we <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_score_ram_arbiter.sv
// Directed bench for score_ram_arbiter with a registered-read RAM model on the RAM pins.
// Define RAM_CLEAR_EN for both bench and RTL to exercise the start-up sweep.
module tb_score_ram_arbiter;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      req, we;
  logic [4*AW-1:0] addr_in;
  logic [4*DW-1:0] wdata_in;
  logic [3:0]      ack, rvalid;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic            ram_we;
  logic [DW-1:0]   ram_rdata;

  logic [DW-1:0] mem [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  score_ram_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .ack       (ack),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .busy      (busy),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  // RAM model: write on ram_we, read data valid the cycle after the address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] w, input int who,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req = r;
    we  = w;
    addr_in[who*AW +: AW]  = a;
    wdata_in[who*DW +: DW] = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},    ack,       0);
    chk({tag, "_rvalid"}, rvalid,    0);
    chk({tag, "_rdata"},  rdata,     0);
    chk({tag, "_busy"},   busy,      0);
    chk({tag, "_we"},     ram_we,    0);
    chk({tag, "_addr"},   ram_addr,  0);
    chk({tag, "_wdata"},  ram_wdata, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] exp5;

    reset = 1'b0; req = '0; we = '0; addr_in = '0; wdata_in = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("rst");

`ifdef RAM_CLEAR_EN
    // Sweep after release; requester 1 read of addr 5 waits behind it.
    drive(4'b0010, 4'b0000, 1, 3'd5, 8'h00);
    reset = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      chk("clr_we",    ram_we,    1);
      chk("clr_addr",  ram_addr,  k);
      chk("clr_wdata", ram_wdata, 0);
      chk("clr_busy",  busy,      1);
      chk("clr_ack",   ack,       0);
    end
    @(negedge clk);
    chk("clr_end_we",   ram_we, 0);
    chk("clr_end_busy", busy,   0);
    chk("clr_end_ack",  ack,    0);
    @(negedge clk);
    chk("clr_ack1", ack, 4'b0010);
    req = '0;
    repeat (2) @(negedge clk);
    chk("clr_rvalid", rvalid, 4'b0010);
    chk("clr_rdata",  rdata,  8'h00);
`else
    reset = 1'b1;
`endif

    // Test 1: requester 0 writes 05 to addr 2.
    drive(4'b0001, 4'b0001, 0, 3'd2, 8'h05);
    @(negedge clk);
    chk("t1_ack",   ack,       4'b0001);
    chk("t1_we",    ram_we,    1);
    chk("t1_addr",  ram_addr,  2);
    chk("t1_wdata", ram_wdata, 8'h05);
    chk("t1_busy",  busy,      1);
    req = '0;
    @(negedge clk);
    chk("t1_busy2", busy,   0);
    chk("t1_ack2",  ack,    0);
    chk("t1_we2",   ram_we, 0);
    chk("t1_ram",   mem[2], 8'h05);

    // Test 2: requester 3 reads addr 2.
    drive(4'b1000, 4'b0000, 3, 3'd2, 8'h00);
    @(negedge clk);
    chk("t2_ack",  ack,      4'b1000);
    chk("t2_we",   ram_we,   0);
    chk("t2_addr", ram_addr, 2);
    req = '0;
    @(negedge clk);
    chk("t2_ack2",   ack,    0);
    chk("t2_rv_n2",  rvalid, 0);
    chk("t2_busy2",  busy,   1);
    @(negedge clk);
    chk("t2_rvalid", rvalid, 4'b1000);
    chk("t2_rdata",  rdata,  8'h05);
    chk("t2_busy3",  busy,   0);
    @(negedge clk);
    chk("t2_rv_pulse", rvalid, 0);
    chk("t2_hold",     rdata,  8'h05);

    // Test 3: all four write continuously; round robin 0,1,2,3,0.
    for (int i = 0; i < 4; i++) drive(4'b1111, 4'b1111, i, AW'(4 + i), DW'(8'h10 + i));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        chk("t3_ack",  ack,      4'b0001 << order[k/2]);
        chk("t3_addr", ram_addr, 4 + order[k/2]);
      end else begin
        chk("t3_gap", ack, 0);
      end
    end
    req = '0;
    chk("t3_mem4", mem[4], 8'h10);
    chk("t3_mem7", mem[7], 8'h13);

    // Test 4: reset during RDWAIT aborts the read.
    drive(4'b0100, 4'b0000, 2, 3'd5, 8'h00);
    @(negedge clk);
    chk("t4_ack", ack, 4'b0100);
    req = '0;
    @(negedge clk);
    chk("t4_busy", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("t4_abort");
    @(negedge clk);
    chk("t4_no_rvalid", rvalid, 0);
    reset = 1'b1;
`ifdef RAM_CLEAR_EN
    repeat (DEPTH + 1) @(negedge clk);
    exp5 = 8'h00;
`else
    exp5 = 8'h11;
`endif
    drive(4'b0010, 4'b0000, 1, 3'd5, 8'h00);
    @(negedge clk);
    chk("t4_ack2", ack, 4'b0010);
    req = '0;
    repeat (2) @(negedge clk);
    chk("t4_rvalid", rvalid, 4'b0010);
    chk("t4_rdata",  rdata,  exp5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
